// File: rtl/complex_accum.sv
// Complex block accumulator: sums LEN signed (real, imag) samples into ACC_W-bit
// wrapping accumulators, holds the result until the downstream handshake.
module complex_accum #(
  parameter int LEN   = 8,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_real,
  input  logic [15:0]      in_imag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_real,
  output logic [ACC_W-1:0] out_imag,
  output logic             out_ovf,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; valid never depends on ready, and data is stable while valid waits.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCUM = 2'd1, S_HOLD = 2'd2} state_t;

  localparam logic [7:0] LAST = 8'(LEN - 1);

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_cnt, w_cnt_nxt;
  logic [ACC_W-1:0] r_acc_re, r_acc_im, w_acc_re_nxt, w_acc_im_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic [ACC_W-1:0] w_ext_re, w_ext_im, w_sum_re, w_sum_im;
  logic             w_ovf_re, w_ovf_im, w_accept;

  assign w_ext_re = {{(ACC_W-16){in_real[15]}}, in_real};
  assign w_ext_im = {{(ACC_W-16){in_imag[15]}}, in_imag};
  assign w_sum_re = r_acc_re + w_ext_re;
  assign w_sum_im = r_acc_im + w_ext_im;

  // Signed overflow: equal operand signs producing a result of the other sign.
  assign w_ovf_re = (r_acc_re[ACC_W-1] == w_ext_re[ACC_W-1]) &&
                    (w_sum_re[ACC_W-1] != r_acc_re[ACC_W-1]);
  assign w_ovf_im = (r_acc_im[ACC_W-1] == w_ext_im[ACC_W-1]) &&
                    (w_sum_im[ACC_W-1] != r_acc_im[ACC_W-1]);

  assign in_ready  = !rst && (r_state != S_HOLD);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == S_HOLD);
  assign out_real  = r_acc_re;
  assign out_imag  = r_acc_im;
  assign out_ovf   = r_ovf;
  assign dbg_state = r_state;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_acc_re_nxt = r_acc_re;
    w_acc_im_nxt = r_acc_im;
    w_ovf_nxt    = r_ovf;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_acc_re_nxt = w_ext_re;
          w_acc_im_nxt = w_ext_im;
          w_cnt_nxt    = 8'd1;
          w_state_nxt  = (LEN == 1) ? S_HOLD : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (w_accept) begin
          w_acc_re_nxt = w_sum_re;
          w_acc_im_nxt = w_sum_im;
          w_cnt_nxt    = r_cnt + 8'd1;
          w_ovf_nxt    = r_ovf | w_ovf_re | w_ovf_im;
          if (r_cnt == LAST) w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          w_state_nxt  = S_IDLE;
          w_cnt_nxt    = 8'd0;
          w_acc_re_nxt = '0;
          w_acc_im_nxt = '0;
          w_ovf_nxt    = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 8'd0;
      r_acc_re <= '0;
      r_acc_im <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_acc_re <= w_acc_re_nxt;
      r_acc_im <= w_acc_im_nxt;
      r_ovf    <= w_ovf_nxt;
    end
  end

endmodule

// File: doc/complex_accum.md
COMPLEX_ACCUM -- requirements
Module: complex_accum

Interface
REQ-001 The block SHALL have parameter LEN, default 8, meaning the number of accepted samples per block (legal range 1..255).
REQ-002 The block SHALL have parameter ACC_W, default 24, meaning the signed accumulator and output width (legal range 17..32).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the input sample is present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept a sample.
REQ-007 The block SHALL have port in_real, input, 16 bits signed: real part of the complex product.
REQ-008 The block SHALL have port in_imag, input, 16 bits signed: imaginary part of the complex product.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the block sum is available.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the downstream stage accepts the sum.
REQ-011 The block SHALL have port out_real, output, ACC_W bits signed: accumulated real sum.
REQ-012 The block SHALL have port out_imag, output, ACC_W bits signed: accumulated imaginary sum.
REQ-013 The block SHALL have port out_ovf, output, 1 bit: sticky overflow flag for the current block.

Function
REQ-014 A sample is accepted SHALL mean a rising edge with in_valid=1 and in_ready=1; cycles with in_valid=0 do not count and do not change the sums.
REQ-015 The block SHALL implement three states: IDLE (count=0), ACCUM (0<count<LEN) and HOLD (sum complete).
REQ-016 In IDLE and ACCUM, in_ready SHALL be 1 and out_valid 0; in HOLD, in_ready SHALL be 0 and out_valid 1.
REQ-017 In IDLE, an accepted sample SHALL load the accumulators with the sign-extended sample and set count=1. The next state is ACCUM, or HOLD if LEN=1.
REQ-018 In ACCUM, an accepted sample SHALL add the sign-extended sample to each accumulator and increment count. When the accepted sample is the LEN-th, the next state is HOLD.
REQ-019 out_valid SHALL rise on the clock edge that accepts the LEN-th sample, and is therefore visible in the following cycle (latency 1 cycle).
REQ-020 Arithmetic SHALL wrap modulo 2^ACC_W, independently for the real and imaginary accumulators.
REQ-021 out_ovf SHALL be set when either addition has two operands of the same sign and a result of the opposite sign. It stays set until the block leaves HOLD.
REQ-022 In HOLD, out_real, out_imag and out_ovf SHALL remain stable while out_ready=0, and any in_valid is ignored.
REQ-023 In HOLD with out_ready=1, the next state SHALL be IDLE, with out_valid=0, accumulators=0, out_ovf=0 and count=0. No sample is accepted in that same cycle.
REQ-024 out_real and out_imag SHALL present the accumulator contents in every state; they are meaningful only while out_valid=1.

Reset
REQ-025 While rst=1, the block SHALL immediately force state=IDLE, count=0, both accumulators 0, out_ovf=0, out_valid=0 and in_ready=0. in_ready returns to 1 in the first cycle after rst deasserts.
REQ-026 An assertion of rst in ACCUM or HOLD SHALL discard the partial or pending sum. The next accepted sample after reset starts a new block.

Verification
REQ-027 LEN=4, back-to-back samples (1,2),(3,4),(-5,6),(7,-8), out_ready=1 -> out_valid=1 exactly one cycle after the 4th sample, out=(6,4), out_ovf=0, then IDLE.
REQ-028 LEN=2, multiplier products (0,1875) then (-5,10) -> out=(-5,1885).
REQ-029 LEN=4 with in_valid low for 3 cycles between each sample -> the same sums as REQ-027, and out_valid rises only after the 4th accepted sample.
REQ-030 out_ready held 0 for 5 cycles in HOLD while in_valid=1 with varying data -> outputs unchanged, in_ready=0, no sample absorbed. The block goes to IDLE on the cycle after out_ready=1.
REQ-031 Assert rst after 2 of 4 samples, then send a full block of (1,1) x4 -> out=(4,4), with no trace of the earlier samples.
REQ-032 ACC_W=17, LEN=3, three samples (32767,0) -> out_real=-32771, out_imag=0, out_ovf=1. out_ovf clears after the out_ready handshake.
